mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_resp_pkg.sv | 18 +
 rtl/word_ram.sv | 32 +++
 rtl/mem_responder.sv | 128 ++++++++++++
 tb/tb_mem_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types, defaults and address checking for the memory responder.
package mem_resp_pkg;

  localparam int DEPTH_DEF   = 256;
  localparam int LATENCY_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // A request is bad when it is not word aligned or addresses past the last word.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned idx_bits);
    return (addr[1:0] != 2'b00) || ((addr >> (idx_bits + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/word_ram.sv
// Single-port 32-bit word RAM with byte write enables and a registered read port.
module word_ram #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [3:0]               be_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // NOTE: the array and read register have no reset; a reset would block RAM inference and memory is defined only once written.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Request/response memory slave: accepts one request, waits LATENCY cycles, answers and holds until taken.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW   = $clog2(DEPTH);
  localparam bit LAT1 = (LATENCY == 1);

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic          we_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic          err_q;
  logic          rsp_err_q;
  logic          rsp_load_q;

  logic          accept;
  logic          enter_resp;
  logic          acc_we;
  logic [AW-1:0] acc_idx;
  logic [31:0]   acc_wdata;
  logic [3:0]    acc_be;
  logic          acc_err;
  logic [31:0]   ram_rdata;

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign accept     = req_valid && req_ready;
  assign enter_resp = (LAT1 && accept) || (state_q == WAIT && cnt_q == 4'd0);

  // With LATENCY=1 the RAM is accessed on the accept edge itself, so it must see the live request.
  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    acc_we    = we_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    acc_err   = err_q;
    if (state_q == IDLE) begin
      acc_we    = req_we;
      acc_idx   = req_addr[AW+1:2];
      acc_wdata = req_wdata;
      acc_be    = req_be;
      acc_err   = addr_err(req_addr, AW);
    end
  end

  word_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .en_i    (enter_resp && !acc_err && rst_n),
    .we_i    (acc_we),
    .be_i    (acc_be),
    .addr_i  (acc_idx),
    .wdata_i (acc_wdata),
    .rdata_o (ram_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= 32'd0;
      be_q       <= 4'd0;
      err_q      <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_load_q <= 1'b0;
    end else begin
      if (enter_resp) begin
        rsp_err_q  <= acc_err;
        rsp_load_q <= !acc_we && !acc_err;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            idx_q   <= req_addr[AW+1:2];
            wdata_q <= req_wdata;
            be_q    <= req_be;
            err_q   <= addr_err(req_addr, AW);
            if (LAT1) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 4'(LATENCY - 2);
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) state_q <= RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        RESP: begin
          if (rsp_ready) begin
            state_q    <= IDLE;
            rsp_err_q  <= 1'b0;
            rsp_load_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_rdata = rsp_load_q ? ram_rdata : 32'd0;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: one table of transactions replayed on LATENCY=2, 1 and 15 builds, plus reset and throughput sequences.
module tb_mem_responder;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  localparam int NVEC = 15;

  logic        clk;
  logic [2:0]  rst_n, req_valid, req_we, rsp_ready;
  logic [2:0]  req_ready, rsp_valid, rsp_err;
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic [31:0] rsp_rdata [3];

  vec_t vecs [NVEC];
  exp_t sb [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(.DEPTH(256), .LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 15))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_be    (req_be[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 15);
  endfunction

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, input int hold, input logic [31:0] er, input logic ee);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.be = be; v.hold = hold;
    v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (dut %0d): got %h expected %h", name, d, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input int d);
    check({tag, "_req_ready"}, d, 32'(req_ready[d]), 32'd1);
    check({tag, "_rsp_valid"}, d, 32'(rsp_valid[d]), 32'd0);
    check({tag, "_rsp_rdata"}, d, rsp_rdata[d], 32'd0);
    check({tag, "_rsp_err"},   d, 32'(rsp_err[d]), 32'd0);
  endtask

  task automatic drive_req(input int d, input vec_t v);
    req_valid[d] = 1'b1;
    req_we[d]    = v.we;
    req_addr[d]  = v.addr;
    req_wdata[d] = v.wdata;
    req_be[d]    = v.be;
  endtask

  task automatic scramble(input int d);
    req_valid[d] = 1'b0;
    req_we[d]    = 1'($urandom);
    req_addr[d]  = $urandom;
    req_wdata[d] = $urandom;
    req_be[d]    = 4'($urandom);
  endtask

  task automatic txn(input int d, input vec_t v);
    exp_t e;
    int   n;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    sb.push_back(e);
    @(negedge clk);
    check("req_ready_before", d, 32'(req_ready[d]), 32'd1);
    drive_req(d, v);
    @(negedge clk);
    scramble(d);
    n = 1;
    while (!rsp_valid[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rsp_latency", d, 32'(n), 32'(lat_of(d)));
    e = sb.pop_front();
    check("rsp_rdata", d, rsp_rdata[d], e.rdata);
    check("rsp_err",   d, 32'(rsp_err[d]), 32'(e.err));
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", d, 32'(rsp_valid[d]), 32'd1);
      check("bp_rsp_rdata", d, rsp_rdata[d], e.rdata);
      check("bp_req_ready", d, 32'(req_ready[d]), 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    check("after_hs_rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
    check("after_hs_req_ready", d, 32'(req_ready[d]), 32'd1);
    rsp_ready[d] = 1'b0;
  endtask

  task automatic throughput(input int d);
    int last;
    int gaps;
    last = -1;
    gaps = 0;
    @(negedge clk);
    drive_req(d, mk(1'b1, 32'h40, 32'h0, 4'h0, 0, 32'h0, 1'b0));
    rsp_ready[d] = 1'b1;
    for (int cyc = 0; cyc < 100 && gaps < 3; cyc++) begin
      if (req_ready[d]) begin
        if (last >= 0) begin
          check("accept_spacing", d, 32'(cyc - last), 32'(lat_of(d) + 1));
          gaps++;
        end
        last = cyc;
      end
      @(negedge clk);
    end
    check("accept_count", d, 32'(gaps), 32'd3);
    req_valid[d] = 1'b0;
    repeat (lat_of(d) + 2) @(negedge clk);
    rsp_ready[d] = 1'b0;
  endtask

  initial begin
    rst_n     = 3'b000;
    req_valid = 3'b000;
    req_we    = 3'b000;
    rsp_ready = 3'b000;
    for (int d = 0; d < 3; d++) begin
      req_addr[d] = 32'h0; req_wdata[d] = 32'h0; req_be[d] = 4'h0;
    end

    vecs[0]  = mk(1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 0, 32'h0,        1'b0);
    vecs[1]  = mk(1'b0, 32'h10,       32'h0,        4'h0, 0, 32'hDEADBEEF, 1'b0);
    vecs[2]  = mk(1'b1, 32'h20,       32'h11223344, 4'hF, 0, 32'h0,        1'b0);
    vecs[3]  = mk(1'b1, 32'h20,       32'hAABBCCDD, 4'h5, 0, 32'h0,        1'b0);
    vecs[4]  = mk(1'b0, 32'h20,       32'h0,        4'h0, 0, 32'h11BB33DD, 1'b0);
    vecs[5]  = mk(1'b1, 32'h0,        32'hCAFEF00D, 4'hF, 0, 32'h0,        1'b0);
    vecs[6]  = mk(1'b0, 32'h13,       32'h0,        4'h0, 0, 32'h0,        1'b1);
    vecs[7]  = mk(1'b1, 32'h400,      32'h12345678, 4'hF, 0, 32'h0,        1'b1);
    vecs[8]  = mk(1'b0, 32'h0,        32'h0,        4'h0, 0, 32'hCAFEF00D, 1'b0);
    vecs[9]  = mk(1'b1, 32'h20,       32'hFFFFFFFF, 4'h0, 0, 32'h0,        1'b0);
    vecs[10] = mk(1'b0, 32'h20,       32'h0,        4'h0, 5, 32'h11BB33DD, 1'b0);
    vecs[11] = mk(1'b1, 32'h3FC,      32'hA5A50001, 4'hF, 0, 32'h0,        1'b0);
    vecs[12] = mk(1'b0, 32'h3FC,      32'h0,        4'h0, 0, 32'hA5A50001, 1'b0);
    vecs[13] = mk(1'b0, 32'h80000000, 32'h0,        4'h0, 0, 32'h0,        1'b1);
    vecs[14] = mk(1'b1, 32'h8,        32'h00000077, 4'hF, 0, 32'h0,        1'b0);

    #1;
    for (int d = 0; d < 3; d++) check_idle_outputs("in_reset", d);
    repeat (2) @(negedge clk);
    rst_n = 3'b111;

    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < NVEC; i++) txn(d, vecs[i]);
    end

    // Abandon a store to 0x8 while it is still waiting; the old word must survive.
    @(negedge clk);
    check("req_ready_before", 0, 32'(req_ready[0]), 32'd1);
    drive_req(0, mk(1'b1, 32'h8, 32'h00000055, 4'hF, 0, 32'h0, 1'b0));
    @(negedge clk);
    scramble(0);
    check("in_wait_req_ready", 0, 32'(req_ready[0]), 32'd0);
    rst_n[0] = 1'b0;
    #1;
    check_idle_outputs("reset_in_wait", 0);
    repeat (2) @(negedge clk);
    check_idle_outputs("held_reset", 0);
    rst_n[0] = 1'b1;
    txn(0, mk(1'b0, 32'h8, 32'h0, 4'h0, 0, 32'h00000077, 1'b0));

    for (int d = 0; d < 3; d++) throughput(d);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
